// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand preparation.
// Captures decoded fields with stall/flush control, optionally forwards
// EX/MEM and MEM/WB results, and drives the ALU operands and ALU control.
// Optional feature macro: ID_EX_FWD_EN (defined = result forwarding enabled;
// undefined = operands come straight from the registered read data).
module id_ex_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  id_pc,
  input  logic [WIDTH-1:0]  id_rs1_data,
  input  logic [WIDTH-1:0]  id_rs2_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src_a,
  input  logic              id_alu_src_b,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic [1:0]        id_result_src,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [WIDTH-1:0]  exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [WIDTH-1:0]  wb_result,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_ctrl,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic [1:0]        ex_result_src,
  output logic [WIDTH-1:0]  ex_pc,
  output logic              ex_illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [1:0]        alu_op;
    logic              alu_src_a;
    logic              alu_src_b;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
  } id_ex_t;

  id_ex_t ex_reg;
  id_ex_t ex_next;

  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;
  logic [2:0]       ctrl_dec;
  logic             illegal_dec;

  // Gather the decode fields; write enables only count for real instructions
  always_comb begin
    ex_next            = '0;
    ex_next.valid      = id_valid;
    ex_next.pc         = id_pc;
    ex_next.rs1_data   = id_rs1_data;
    ex_next.rs2_data   = id_rs2_data;
    ex_next.imm        = id_imm;
    ex_next.rs1        = id_rs1;
    ex_next.rs2        = id_rs2;
    ex_next.rd         = id_rd;
    ex_next.funct3     = id_funct3;
    ex_next.funct7b5   = id_funct7b5;
    ex_next.alu_op     = id_alu_op;
    ex_next.alu_src_a  = id_alu_src_a;
    ex_next.alu_src_b  = id_alu_src_b;
    ex_next.reg_write  = id_reg_write & id_valid;
    ex_next.mem_write  = id_mem_write & id_valid;
    ex_next.result_src = id_result_src;
  end

  // Pipeline register: flush inserts a zeroed bubble and outranks stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_reg <= '0;
    end else if (flush) begin
      ex_reg <= '0;
    end else if (!stall) begin
      ex_reg <= ex_next;
    end
  end

`ifdef ID_EX_FWD_EN
  // rs1 forwarding: EX/MEM beats MEM/WB, x0 never forwarded
  always_comb begin
    fwd_rs1 = ex_reg.rs1_data;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_reg.rs1)) begin
      fwd_rs1 = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_reg.rs1)) begin
      fwd_rs1 = wb_result;
    end
  end

  // rs2 forwarding: same priority as rs1, also feeds store data
  always_comb begin
    fwd_rs2 = ex_reg.rs2_data;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_reg.rs2)) begin
      fwd_rs2 = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_reg.rs2)) begin
      fwd_rs2 = wb_result;
    end
  end
`else
  // Without forwarding, hazards are resolved upstream by stalling
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd, exm_reg_write, exm_result,
                        wb_rd, wb_reg_write, wb_result,
                        ex_reg.rs1, ex_reg.rs2};
  assign fwd_rs1 = ex_reg.rs1_data;
  assign fwd_rs2 = ex_reg.rs2_data;
`endif

  // ALU control decode from the registered instruction fields
  always_comb begin
    ctrl_dec    = ALU_ADD;
    illegal_dec = 1'b0;
    unique case (ex_reg.alu_op)
      2'b00: ctrl_dec = ALU_ADD;
      2'b01: ctrl_dec = ALU_SUB;
      2'b10: begin
        unique case (ex_reg.funct3)
          // Immediate form (src_b = 1) is ADDI, which never subtracts
          3'b000: ctrl_dec = (ex_reg.funct7b5 && !ex_reg.alu_src_b) ? ALU_SUB : ALU_ADD;
          3'b001: ctrl_dec = ALU_SLL;
          3'b101: ctrl_dec = ex_reg.funct7b5 ? ALU_SRA : ALU_SRL;
          3'b100: ctrl_dec = ALU_XOR;
          3'b110: ctrl_dec = ALU_OR;
          3'b111: ctrl_dec = ALU_AND;
          default: begin
            // SLT/SLTU have no ALU support
            ctrl_dec    = ALU_ADD;
            illegal_dec = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_dec    = ALU_ADD;
        illegal_dec = 1'b1;
      end
    endcase
  end

  assign alu_a         = ex_reg.alu_src_a ? ex_reg.pc  : fwd_rs1;
  assign alu_b         = ex_reg.alu_src_b ? ex_reg.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_ctrl      = ctrl_dec;
  assign ex_illegal    = illegal_dec & ex_reg.valid;
  assign ex_valid      = ex_reg.valid;
  assign ex_rd         = ex_reg.rd;
  assign ex_reg_write  = ex_reg.reg_write & ex_reg.valid;
  assign ex_mem_write  = ex_reg.mem_write & ex_reg.valid;
  assign ex_result_src = ex_reg.result_src;
  assign ex_pc         = ex_reg.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the stage.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [1:0]  id_alu_op;
  logic        id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_write;
  logic [1:0]  id_result_src;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [2:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_write, ex_illegal;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;

  int checks = 0;
  int failures = 0;

  // Model of the instruction currently held in EX
  logic        m_valid, m_f7, m_sa, m_sb, m_rw, m_mw;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_op, m_rsrc;

  id_ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_op(id_alu_op),
    .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_result_src(id_result_src), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // What the held instruction should see as the value of register rs
  function automatic logic [31:0] model_reg(input logic [4:0] rs, input logic [31:0] rf);
    if (FWD && exm_reg_write && rs != 0 && exm_rd == rs) return exm_result;
    if (FWD && wb_reg_write && rs != 0 && wb_rd == rs) return wb_result;
    return rf;
  endfunction

  function automatic logic [2:0] model_ctrl();
    if (m_op == 2'd1) return 3'd1;
    if (m_op != 2'd2) return 3'd0;
    case (m_f3)
      3'd0: return (m_f7 && !m_sb) ? 3'd1 : 3'd0;
      3'd1: return 3'd4;
      3'd5: return m_f7 ? 3'd6 : 3'd5;
      3'd4: return 3'd7;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic model_illegal();
    return m_valid && (m_op == 2'd3 || (m_op == 2'd2 && (m_f3 == 3'd2 || m_f3 == 3'd3)));
  endfunction

  task automatic model_clear();
    {m_valid, m_f7, m_sa, m_sb, m_rw, m_mw} = '0;
    {m_pc, m_d1, m_d2, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_f3, m_op, m_rsrc} = '0;
  endtask

  // One rising edge; the model applies the same inputs the DUT saw
  task automatic tick();
    @(posedge clk);
    if (reset || flush) begin
      model_clear();
    end else if (!stall) begin
      m_valid = id_valid; m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
      m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_f3 = id_funct3; m_f7 = id_funct7b5; m_op = id_alu_op;
      m_sa = id_alu_src_a; m_sb = id_alu_src_b; m_rsrc = id_result_src;
      m_rw = id_reg_write && id_valid; m_mw = id_mem_write && id_valid;
    end
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [2:0] f3, input logic f7,
                           input logic [1:0] op, input logic sb, input logic [31:0] imm);
    id_valid = 1'b1; id_pc = 32'h0000_0040; id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2; id_funct3 = f3; id_funct7b5 = f7;
    id_alu_op = op; id_alu_src_a = 1'b0; id_alu_src_b = sb; id_imm = imm;
    id_rd = 5'd9; id_reg_write = 1'b1; id_mem_write = 1'b0; id_result_src = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    set_instr(5'd1, 32'd10, 5'd2, 32'd3, 3'd0, 1'b0, 2'b00, 1'b0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_load ex_valid got=%0b exp=1", ex_valid); end
    // Assert reset mid-cycle: outputs must clear without a clock edge
    reset = 1'b1;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    checks++;
    if ({ex_reg_write, ex_mem_write, ex_illegal} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {ex_reg_write, ex_mem_write, ex_illegal}); end
    checks++;
    if (ex_rd !== 5'd0 || ex_pc !== 32'd0) begin failures++; $display("FAIL reset_rd_pc got=%0h/%0h exp=0/0", ex_rd, ex_pc); end
    checks++;
    if (alu_ctrl !== 3'd0) begin failures++; $display("FAIL reset_alu_ctrl got=%0d exp=0", alu_ctrl); end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || ex_store_data !== 32'd0) begin
      failures++; $display("FAIL reset_operands got=%0h/%0h/%0h exp=0/0/0", alu_a, alu_b, ex_store_data);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_alu_decode();
    set_instr(5'd1, 32'd10, 5'd2, 32'd3, 3'd0, 1'b1, 2'b10, 1'b0, 32'd3);
    tick();
    checks++;
    if (alu_ctrl !== 3'b001) begin failures++; $display("FAIL sub_ctrl got=%0d exp=1", alu_ctrl); end
    checks++;
    if (alu_a !== 32'd10 || alu_b !== 32'd3) begin failures++; $display("FAIL sub_operands got=%0d/%0d exp=10/3", alu_a, alu_b); end
    id_alu_src_b = 1'b1;
    tick();
    checks++;
    if (alu_ctrl !== 3'b000 || alu_b !== 32'd3) begin failures++; $display("FAIL addi_ctrl got=%0d/%0d exp=0/3", alu_ctrl, alu_b); end
    id_funct3 = 3'b101; id_funct7b5 = 1'b1; id_alu_src_b = 1'b0;
    tick();
    checks++;
    if (alu_ctrl !== 3'b110) begin failures++; $display("FAIL sra_ctrl got=%0d exp=6", alu_ctrl); end
    id_funct7b5 = 1'b0;
    tick();
    checks++;
    if (alu_ctrl !== 3'b101) begin failures++; $display("FAIL srl_ctrl got=%0d exp=5", alu_ctrl); end
    id_funct3 = 3'b010;
    tick();
    checks++;
    if (alu_ctrl !== 3'b000 || ex_illegal !== 1'b1) begin failures++; $display("FAIL slt_illegal got=%0d/%0b exp=0/1", alu_ctrl, ex_illegal); end
    // An unsupported funct3 in a bubble must not raise illegal
    id_valid = 1'b0;
    tick();
    checks++;
    if (ex_illegal !== 1'b0 || ex_reg_write !== 1'b0) begin failures++; $display("FAIL bubble_illegal got=%0b/%0b exp=0/0", ex_illegal, ex_reg_write); end
  endtask

  task automatic test_forwarding();
    set_instr(5'd5, 32'h1234, 5'd5, 32'h1234, 3'd0, 1'b0, 2'b00, 1'b0, 32'd0);
    tick();
    exm_rd = 5'd5; exm_reg_write = 1'b1; exm_result = 32'hAAAA;
    wb_rd  = 5'd5; wb_reg_write  = 1'b1; wb_result  = 32'hBBBB;
    #1;
    checks++;
    if (alu_a !== (FWD ? 32'hAAAA : 32'h1234)) begin failures++; $display("FAIL fwd_exm_wins got=%0h exp=%0h", alu_a, FWD ? 32'hAAAA : 32'h1234); end
    exm_reg_write = 1'b0;
    #1;
    checks++;
    if (alu_a !== (FWD ? 32'hBBBB : 32'h1234)) begin failures++; $display("FAIL fwd_wb got=%0h exp=%0h", alu_a, FWD ? 32'hBBBB : 32'h1234); end
    checks++;
    if (ex_store_data !== (FWD ? 32'hBBBB : 32'h1234)) begin failures++; $display("FAIL fwd_store got=%0h exp=%0h", ex_store_data, FWD ? 32'hBBBB : 32'h1234); end
    exm_reg_write = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++;
    if (alu_a !== 32'h1234) begin failures++; $display("FAIL fwd_x0 got=%0h exp=1234", alu_a); end
    // x0 read with an x0 writer in flight stays at register data
    set_instr(5'd0, 32'h0, 5'd0, 32'h0, 3'd0, 1'b0, 2'b00, 1'b0, 32'd0);
    exm_result = 32'hDEAD;
    tick();
    checks++;
    if (alu_a !== 32'h0) begin failures++; $display("FAIL fwd_x0_src got=%0h exp=0", alu_a); end
    exm_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic test_stall_flush();
    set_instr(5'd3, 32'h77, 5'd4, 32'h88, 3'd0, 1'b0, 2'b00, 1'b0, 32'd0);
    id_pc = 32'h100; id_rd = 5'd7; id_mem_write = 1'b1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h200 + i; id_rd = 5'd20 + 5'(i); id_rs1_data = 32'hF0 + i; id_valid = 1'b0;
      tick();
      checks++;
      if (ex_pc !== 32'h100 || ex_rd !== 5'd7 || ex_valid !== 1'b1 || alu_a !== 32'h77) begin
        failures++; $display("FAIL stall_hold pc=%0h rd=%0d v=%0b a=%0h exp=100/7/1/77", ex_pc, ex_rd, ex_valid, alu_a);
      end
    end
    // Held instruction picks up a result retiring during the stall
    wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 32'h5555;
    #1;
    checks++;
    if (alu_a !== (FWD ? 32'h5555 : 32'h77)) begin failures++; $display("FAIL stall_fwd got=%0h exp=%0h", alu_a, FWD ? 32'h5555 : 32'h77); end
    wb_reg_write = 1'b0;
    flush = 1'b1; id_valid = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
      failures++; $display("FAIL flush_over_stall got=%0b/%0b/%0b exp=0/0/0", ex_valid, ex_reg_write, ex_mem_write);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 7) == 0);
      id_valid = $urandom_range(0, 3) != 0; id_pc = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
      id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom); id_alu_op = 2'($urandom);
      id_alu_src_a = 1'($urandom); id_alu_src_b = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_write = 1'($urandom); id_result_src = 2'($urandom);
      exm_rd = 5'($urandom_range(0, 3)); exm_reg_write = 1'($urandom); exm_result = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_result = $urandom;
      tick();
      checks++;
      if (alu_a !== (m_sa ? m_pc : model_reg(m_rs1, m_d1))) begin
        failures++; $display("FAIL rand_alu_a n=%0d got=%0h exp=%0h", n, alu_a, m_sa ? m_pc : model_reg(m_rs1, m_d1));
      end
      checks++;
      if (alu_b !== (m_sb ? m_imm : model_reg(m_rs2, m_d2))) begin
        failures++; $display("FAIL rand_alu_b n=%0d got=%0h exp=%0h", n, alu_b, m_sb ? m_imm : model_reg(m_rs2, m_d2));
      end
      checks++;
      if (ex_store_data !== model_reg(m_rs2, m_d2)) begin
        failures++; $display("FAIL rand_store n=%0d got=%0h exp=%0h", n, ex_store_data, model_reg(m_rs2, m_d2));
      end
      checks++;
      if (alu_ctrl !== model_ctrl() || ex_illegal !== model_illegal()) begin
        failures++; $display("FAIL rand_ctrl n=%0d got=%0d/%0b exp=%0d/%0b", n, alu_ctrl, ex_illegal, model_ctrl(), model_illegal());
      end
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_write, ex_rd, ex_result_src, ex_pc} !== {m_valid, m_rw, m_mw, m_rd, m_rsrc, m_pc}) begin
        failures++; $display("FAIL rand_fields n=%0d got=%0b%0b%0b rd=%0d rs=%0d pc=%0h exp=%0b%0b%0b rd=%0d rs=%0d pc=%0h",
          n, ex_valid, ex_reg_write, ex_mem_write, ex_rd, ex_result_src, ex_pc, m_valid, m_rw, m_mw, m_rd, m_rsrc, m_pc);
      end
      $display("txn %0d stall=%0b flush=%0b valid=%0b ctrl=%0d a=%0h b=%0h", n, stall, flush, ex_valid, alu_ctrl, alu_a, alu_b);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_decode();
    test_forwarding();
    test_stall_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-side operand preparation. It sits directly upstream of the ALU.
- Captures decoded instruction fields each cycle, with stall and flush control.
- Forwards the newest register results from EX/MEM and MEM/WB.
- Drives the ALU operands (a, b) and the 3-bit ALU control, together with the downstream control bits for the EX/MEM stage.

Parameters:
- WIDTH, 32, datapath width of operands, immediate, PC and forwarded results.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all registered contents.
- flush  input  1  load a bubble on the next edge.
- id_valid  input  1  decode stage presents a real instruction.
- id_pc  input  WIDTH  PC of the decoded instruction.
- id_rs1_data, id_rs2_data  input  WIDTH each  register file read data.
- id_imm  input  WIDTH  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  REG_AW each  register addresses.
- id_funct3  input  3  instruction funct3.
- id_funct7b5  input  1  instr[30].
- id_alu_op  input  2  00 = add, 01 = sub, 10 = funct decode.
- id_alu_src_a  input  1  0 = rs1, 1 = pc.
- id_alu_src_b  input  1  0 = rs2, 1 = imm.
- id_reg_write  input  1  downstream control, registered and passed through.
- id_mem_write  input  1  downstream control, registered and passed through.
- id_result_src  input  2  downstream control, registered and passed through.
- exm_rd  input  REG_AW  EX/MEM destination register.
- exm_reg_write  input  1  EX/MEM write enable.
- exm_result  input  WIDTH  EX/MEM result value.
- wb_rd  input  REG_AW  MEM/WB destination register.
- wb_reg_write  input  1  MEM/WB write enable.
- wb_result  input  WIDTH  MEM/WB result value.
- alu_a, alu_b  output  WIDTH each  ALU operands.
- alu_ctrl  output  3  ALU operation select.
- ex_store_data  output  WIDTH  forwarded rs2 value for stores.
- ex_valid  output  1  stage holds a real instruction.
- ex_rd  output  REG_AW  registered destination register.
- ex_reg_write, ex_mem_write  output  1 each  registered controls, gated by ex_valid.
- ex_result_src  output  2  registered result select.
- ex_pc  output  WIDTH  registered PC.
- ex_illegal  output  1  funct3 not supported by the ALU.

Behaviour:
- Reset (asynchronous, immediate):
  - All registers clear to 0: ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0, ex_rd = 0, ex_pc = 0.
  - alu_ctrl = 000. With registers cleared, alu_a, alu_b and ex_store_data are 0 unless forwarding matches rd 0, which is excluded.
- Register update on each rising edge, by priority:
  - flush = 1: ex_valid, reg_write and mem_write clear to 0; other fields are don't-care but also clear to 0. Flush beats stall.
  - else stall = 1: all registers hold.
  - else: all id_* fields are captured. Captured reg_write and mem_write are ANDed with id_valid.
- Latency: decode inputs appear on the outputs one cycle later.
- Forwarding (combinational on the registered rs1/rs2 addresses):
  - Source 1: exm_result if exm_reg_write and exm_rd != 0 and exm_rd == rs.
  - Source 2, otherwise: wb_result if wb_reg_write and wb_rd != 0 and wb_rd == rs.
  - Otherwise: the registered read data.
  - EX/MEM always wins over MEM/WB when both match. x0 is never forwarded.
- Operand selection:
  - alu_a = pc if src_a = 1, else forwarded rs1.
  - alu_b = imm if src_b = 1, else forwarded rs2.
  - ex_store_data = forwarded rs2, always.
- alu_ctrl encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 XOR. It is decoded from the registered fields.
  - alu_op 00 → ADD.
  - alu_op 01 → SUB.
  - alu_op 10, by funct3:
    - 000 → SUB if funct7b5 and src_b = 0, else ADD (ADDI is never SUB).
    - 001 → SLL.
    - 101 → SRA if funct7b5, else SRL. This applies to both R-type and immediate shifts.
    - 100 → XOR.
    - 110 → OR.
    - 111 → AND.
    - 010/011 (SLT/SLTU) → ADD, with ex_illegal = 1.
  - alu_op 11 → ADD, with ex_illegal = 1.
- ex_illegal is only asserted when ex_valid = 1.
- During a stall the forwarding muxes keep tracking live exm/wb inputs. The held instruction therefore picks up results that retire while it is stalled.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as described above.
- Undefined: no forwarding logic. Operands come straight from the registered read data. The exm_*/wb_* inputs are present but ignored, and hazards are left to the stall logic.

Test Plan:
- Reset while holding a valid ADD → all outputs 0 immediately, before any clock edge; ex_valid = 0.
- id: ADD, rs1 = x1 (10), rs2 = x2 (3), funct7b5 = 1, alu_op = 10, src_b = 0 → next cycle alu_ctrl = 001, alu_a = 10, alu_b = 3. Same fields with src_b = 1, imm = 3 → alu_ctrl = 000.
- Registered rs1 = x5, exm_rd = 5 (result 0xAAAA), wb_rd = 5 (result 0xBBBB), both writes set → alu_a = 0xAAAA. Drop exm_reg_write → alu_a = 0xBBBB. Set rd = 0 on both → alu_a = register data.
- funct3 = 101 with funct7b5 = 1 → alu_ctrl = 110; with funct7b5 = 0 → 101. funct3 = 010 → alu_ctrl = 000, ex_illegal = 1.
- stall = 1 for 3 cycles with new id_* inputs → outputs unchanged. stall = 1 and flush = 1 together → ex_valid = 0, ex_reg_write = 0 after the edge.
- Build without ID_EX_FWD_EN, exm_rd matching rs1 → alu_a = registered rs1 data.
